// File: rtl/path_req_scheduler_if.sv
// Bundle of requester, engine and output-stream signals for the path request
// scheduler. The scheduler uses the slave view; the environment (requesters,
// planner engine, response consumer) uses the master view.
interface path_req_scheduler_if #(
  parameter int NODE_W = 6
);
  // requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [NODE_W-1:0] req0_src;
  logic [NODE_W-1:0] req0_dst;
  // requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [NODE_W-1:0] req1_src;
  logic [NODE_W-1:0] req1_dst;
  // planner engine
  logic              eng_start;
  logic [NODE_W-1:0] eng_src;
  logic [NODE_W-1:0] eng_dst;
  logic              eng_done;
  logic [NODE_W-1:0] eng_len;
  logic [NODE_W-1:0] eng_rd_addr;
  logic [NODE_W-1:0] eng_rd_data;
  // response stream
  logic              out_valid;
  logic              out_ready;
  logic [NODE_W-1:0] out_node;
  logic              out_last;
  logic              out_err;
  logic              out_id;

  modport slave (
    input  req0_valid, req0_src, req0_dst,
    output req0_ready,
    input  req1_valid, req1_src, req1_dst,
    output req1_ready,
    output eng_start, eng_src, eng_dst, eng_rd_addr,
    input  eng_done, eng_len, eng_rd_data,
    output out_valid, out_node, out_last, out_err, out_id,
    input  out_ready
  );

  modport master (
    output req0_valid, req0_src, req0_dst,
    input  req0_ready,
    output req1_valid, req1_src, req1_dst,
    input  req1_ready,
    input  eng_start, eng_src, eng_dst, eng_rd_addr,
    output eng_done, eng_len, eng_rd_data,
    input  out_valid, out_node, out_last, out_err, out_id,
    output out_ready
  );
endinterface

// File: rtl/path_req_scheduler.sv
// Path request scheduler: round-robin shares one shortest-path planner engine
// between two requesters, launches it, reads the node list back and streams it
// out one node per beat tagged with the requester id. Bad, unreachable and
// timed-out requests produce a single error beat.
module path_req_scheduler #(
  parameter int NODE_W    = 6,
  parameter int NUM_NODES = 37,
  parameter int TIMEOUT   = 4095
) (
  input  logic                    clk,
  input  logic                    rst_n,
  path_req_scheduler_if.slave     bus
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FETCH  = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [NODE_W:0]   NUM_NODES_X = (NODE_W + 1)'(NUM_NODES);
  localparam logic [NODE_W-1:0] NODE_ONE    = NODE_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LIMIT   = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_MAX     = '1;

  // Saturating increment for the WAIT timer.
  function automatic logic [TMR_W-1:0] timer_inc(input logic [TMR_W-1:0] t);
    return (t == TMR_MAX) ? t : t + TMR_ONE;
  endfunction

  // True when a node index addresses a real arena node.
  function automatic logic node_ok(input logic [NODE_W-1:0] n);
    return {1'b0, n} < NUM_NODES_X;
  endfunction

  logic [2:0]        state_q,     state_d;
  logic              rr_ptr_q,    rr_ptr_d;
  logic [NODE_W-1:0] src_q,       src_d;
  logic [NODE_W-1:0] dst_q,       dst_d;
  logic              id_q,        id_d;
  logic [NODE_W-1:0] idx_q,       idx_d;
  logic [NODE_W-1:0] len_q,       len_d;
  logic [TMR_W-1:0]  timer_q,     timer_d;
  logic              out_valid_q, out_valid_d;
  logic [NODE_W-1:0] out_node_q,  out_node_d;
  logic              out_last_q,  out_last_d;
  logic              out_err_q,   out_err_d;
  logic              out_id_q,    out_id_d;

  logic              grant_vld;
  logic              grant_id;
  logic [NODE_W-1:0] sel_src;
  logic [NODE_W-1:0] sel_dst;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~rr_ptr_q;
    end else if (bus.req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  assign sel_src = grant_id ? bus.req1_src : bus.req0_src;
  assign sel_dst = grant_id ? bus.req1_dst : bus.req0_dst;

  assign bus.req0_ready = (state_q == S_IDLE) && grant_vld && !grant_id;
  assign bus.req1_ready = (state_q == S_IDLE) && grant_vld &&  grant_id;

  assign bus.eng_start = (state_q == S_LAUNCH);
  assign bus.eng_src   = src_q;
  assign bus.eng_dst   = dst_q;
  // The read address follows idx_d, so it already points at the next node in
  // the cycle before FETCH and still equals idx during FETCH; this suits both
  // a combinational and a registered path memory.
  assign bus.eng_rd_addr = idx_d;

  assign bus.out_valid = out_valid_q;
  assign bus.out_node  = out_node_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_id    = out_id_q;

  // Next-state logic for the request / launch / wait / fetch / stream sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    src_d       = src_q;
    dst_d       = dst_q;
    id_d        = id_q;
    idx_d       = idx_q;
    len_d       = len_q;
    timer_d     = timer_q;
    out_valid_d = out_valid_q;
    out_node_d  = out_node_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    out_id_d    = out_id_q;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          src_d    = sel_src;
          dst_d    = sel_dst;
          id_d     = grant_id;
          rr_ptr_d = grant_id;
          if (!node_ok(sel_src) || !node_ok(sel_dst)) begin
            state_d     = S_ERR;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_last_d  = 1'b1;
            out_node_d  = '0;
            out_id_d    = grant_id;
          end else if (sel_src == sel_dst) begin
            // Trivial path: answer directly without the engine.
            state_d     = S_STREAM;
            out_valid_d = 1'b1;
            out_err_d   = 1'b0;
            out_last_d  = 1'b1;
            out_node_d  = sel_src;
            out_id_d    = grant_id;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.eng_done) begin
          if ((bus.eng_len == '0) || ({1'b0, bus.eng_len} > NUM_NODES_X)) begin
            state_d     = S_ERR;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_last_d  = 1'b1;
            out_node_d  = '0;
            out_id_d    = id_q;
          end else begin
            len_d   = bus.eng_len;
            idx_d   = '0;
            state_d = S_FETCH;
          end
        end else if (timer_q == TMR_LIMIT) begin
          state_d     = S_ERR;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_last_d  = 1'b1;
          out_node_d  = '0;
          out_id_d    = id_q;
        end else begin
          timer_d = timer_inc(timer_q);
        end
      end

      S_FETCH: begin
        out_valid_d = 1'b1;
        out_node_d  = bus.eng_rd_data;
        out_last_d  = (idx_q == (len_q - NODE_ONE));
        out_err_d   = 1'b0;
        out_id_d    = id_q;
        state_d     = S_STREAM;
      end

      S_STREAM: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_node_d  = '0;
            out_last_d  = 1'b0;
            out_err_d   = 1'b0;
            out_id_d    = 1'b0;
          end else begin
            idx_d       = idx_q + NODE_ONE;
            out_valid_d = 1'b0;
            state_d     = S_FETCH;
          end
        end
      end

      S_ERR: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_node_d  = '0;
          out_last_d  = 1'b0;
          out_err_d   = 1'b0;
          out_id_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b1;
      src_q       <= '0;
      dst_q       <= '0;
      id_q        <= 1'b0;
      idx_q       <= '0;
      len_q       <= '0;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_node_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      out_node_q  <= out_node_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      out_id_q    <= out_id_d;
    end
  end

endmodule

// File: tb/tb_path_req_scheduler.sv
// Scoreboard bench for path_req_scheduler: expected beats are queued as each
// request is issued; a monitor process pops and compares on every handshake.
module tb_path_req_scheduler;
  localparam int NODE_W    = 6;
  localparam int NUM_NODES = 37;
  localparam int TIMEOUT   = 4095;

  typedef struct packed {
    logic              id;
    logic [NODE_W-1:0] node;
    logic              last;
    logic              err;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  path_req_scheduler_if #(.NODE_W(NODE_W)) bus ();

  path_req_scheduler #(.NODE_W(NODE_W), .NUM_NODES(NUM_NODES), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NODE_W-1:0] mem [0:63];
  assign bus.eng_rd_data = mem[bus.eng_rd_addr];

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int hs_last0 = 0;
  int beat_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && bus.eng_start) start_cnt <= start_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic push(input logic id, input logic [NODE_W-1:0] node, input logic last, input logic err);
    beat_t b;
    b.id = id; b.node = node; b.last = last; b.err = err;
    exp_q.push_back(b);
  endtask

  task automatic monitor();
    beat_t act;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else if (bus.out_valid && bus.out_ready) begin
        act.id = bus.out_id; act.node = bus.out_node;
        act.last = bus.out_last; act.err = bus.out_err;
        beat_cyc = cyc;
        if (act.last && !act.id) hs_last0 = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", act);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'(act), 32'(e));
        end
      end
    end
  endtask

  task automatic do_req(input logic id, input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] d,
                        output int acc_cyc);
    acc_cyc = -1;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_src = s; bus.req1_dst = d; end
    else    begin bus.req0_valid = 1'b1; bus.req0_src = s; bus.req0_dst = d; end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    if (acc_cyc < 0) fail_now("req_accept");
  endtask

  // Plays the planner engine: waits for eng_start, then (lat >= 1) pulses done.
  task automatic do_eng(input int lat, input logic [NODE_W-1:0] len, input bit chk_lat,
                        output int st_cyc);
    st_cyc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.eng_start) begin
        st_cyc = cyc;
        break;
      end
    end
    if (st_cyc < 0) begin
      fail_now("eng_start");
      return;
    end
    if (lat < 1) return;
    repeat (lat) @(posedge clk);
    #1;
    bus.eng_done = 1'b1;
    bus.eng_len  = len;
    @(posedge clk); #1;
    bus.eng_done = 1'b0;
    bus.eng_len  = '0;
    if (chk_lat) begin
      @(negedge clk);
      check("lat_fetch_gap", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("lat_first_beat", 32'(bus.out_valid), 32'd1);
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!ok) fail_now(name);
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.out_valid, bus.out_node, bus.out_last, bus.out_err, bus.out_id,
                bus.eng_start, bus.eng_src, bus.eng_dst, bus.eng_rd_addr,
                bus.req0_ready, bus.req1_ready});
  endfunction

  initial begin
    int a0, a1, st, s0;
    logic [31:0] snap;
    bit seen;

    bus.req0_valid = 1'b0; bus.req0_src = '0; bus.req0_dst = '0;
    bus.req1_valid = 1'b0; bus.req1_src = '0; bus.req1_dst = '0;
    bus.eng_done = 1'b0; bus.eng_len = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    fork
      monitor();
    join_none

    // Reset state
    #12;
    check("reset_outputs", out_vec(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests: req0 wins first, req1 follows right after
    mem[0] = 6'd10; mem[1] = 6'd11; mem[2] = 6'd12;
    s0 = start_cnt;
    push(1'b0, 6'd10, 1'b0, 1'b0);
    push(1'b0, 6'd11, 1'b0, 1'b0);
    push(1'b0, 6'd12, 1'b1, 1'b0);
    push(1'b1, 6'd20, 1'b1, 1'b0);
    fork
      do_req(1'b0, 6'd10, 6'd12, a0);
      do_req(1'b1, 6'd20, 6'd20, a1);
      do_eng(1, 6'd3, 1'b0, st);
    join
    wait_drain("drain_rr1");
    check("rr_req1_accept_after_last", 32'(a1), 32'(hs_last0 + 1));
    check("rr1_starts", 32'(start_cnt - s0), 32'd1);

    // Second simultaneous pair: req0 wins again
    push(1'b0, 6'd7, 1'b1, 1'b0);
    push(1'b1, 6'd8, 1'b1, 1'b0);
    fork
      do_req(1'b0, 6'd7, 6'd7, a0);
      do_req(1'b1, 6'd8, 6'd8, a1);
    join
    wait_drain("drain_rr2");
    check("rr2_order", 32'(a0 < a1), 32'd1);

    // Basic path 33 -> 36
    mem[0] = 6'd33; mem[1] = 6'd34; mem[2] = 6'd35; mem[3] = 6'd36;
    s0 = start_cnt;
    push(1'b0, 6'd33, 1'b0, 1'b0);
    push(1'b0, 6'd34, 1'b0, 1'b0);
    push(1'b0, 6'd35, 1'b0, 1'b0);
    push(1'b0, 6'd36, 1'b1, 1'b0);
    fork
      do_req(1'b0, 6'd33, 6'd36, a0);
      do_eng(2, 6'd4, 1'b1, st);
    join
    wait_drain("drain_basic");
    check("basic_starts", 32'(start_cnt - s0), 32'd1);

    // src == dst: single beat, no engine, one-cycle latency
    s0 = start_cnt;
    push(1'b1, 6'd5, 1'b1, 1'b0);
    do_req(1'b1, 6'd5, 6'd5, a1);
    wait_drain("drain_same");
    check("same_latency", 32'(beat_cyc), 32'(a1 + 1));
    check("same_starts", 32'(start_cnt - s0), 32'd0);

    // Out-of-range source
    s0 = start_cnt;
    push(1'b0, 6'd0, 1'b1, 1'b1);
    do_req(1'b0, 6'd40, 6'd3, a0);
    wait_drain("drain_range");
    check("range_starts", 32'(start_cnt - s0), 32'd0);

    // Engine reports unreachable (len 0)
    s0 = start_cnt;
    push(1'b1, 6'd0, 1'b1, 1'b1);
    fork
      do_req(1'b1, 6'd1, 6'd2, a1);
      do_eng(3, 6'd0, 1'b0, st);
    join
    wait_drain("drain_unreach");
    check("unreach_starts", 32'(start_cnt - s0), 32'd1);

    // Engine never finishes: timeout error
    push(1'b0, 6'd0, 1'b1, 1'b1);
    fork
      do_req(1'b0, 6'd2, 6'd9, a0);
      do_eng(-1, 6'd0, 1'b0, st);
    join
    wait_drain("drain_timeout");
    check("timeout_latency", 32'(beat_cyc - st), 32'(TIMEOUT + 2));

    // Stray late done, then a normal request
    bus.eng_done = 1'b1; bus.eng_len = 6'd5;
    @(posedge clk); #1;
    bus.eng_done = 1'b0; bus.eng_len = '0;
    @(posedge clk); #1;
    mem[0] = 6'd3; mem[1] = 6'd4;
    push(1'b1, 6'd3, 1'b0, 1'b0);
    push(1'b1, 6'd4, 1'b1, 1'b0);
    fork
      do_req(1'b1, 6'd3, 6'd4, a1);
      do_eng(1, 6'd2, 1'b1, st);
    join
    wait_drain("drain_stray");

    // Stall mid-path, then reset during STREAM
    mem[0] = 6'd0; mem[1] = 6'd1; mem[2] = 6'd2; mem[3] = 6'd3;
    push(1'b0, 6'd0, 1'b0, 1'b0);
    push(1'b0, 6'd1, 1'b0, 1'b0);
    push(1'b0, 6'd2, 1'b0, 1'b0);
    push(1'b0, 6'd3, 1'b1, 1'b0);
    fork
      do_req(1'b0, 6'd0, 6'd3, a0);
      do_eng(1, 6'd4, 1'b0, st);
    join
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("stall_first_beat");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("stall_second_beat");
    snap = out_vec();
    check("stall_node", 32'(bus.out_node), 32'd1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("stall_hold", out_vec(), snap);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    push(1'b1, 6'd6, 1'b1, 1'b0);
    do_req(1'b1, 6'd6, 6'd6, a1);
    wait_drain("drain_after_reset");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
